// File: rtl/bmu_ctrl.sv
// Branch-metric-unit sequencer: loads 3-pair symbol groups, waits for the BMU result, refreshes on request.
// Optional WAIT-state timeout enabled by defining BMU_CTRL_TIMEOUT_EN.
module bmu_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] sym_data,
  input  logic       sym_first,
  output logic       sym_ready,
  input  logic       refresh_req,
  input  logic       bmu_valid,
  output logic [1:0] bit_pair_0,
  output logic [1:0] bit_pair_1,
  output logic [1:0] bit_pair_2,
  output logic       refresh,
  output logic       group_done,
  output logic [7:0] group_cnt,
  output logic       busy,
  output logic       err_sync,
  output logic       err_timeout
);

  typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, WAIT, DONE, REFRESH} state_t;

  state_t state, nxt;
  logic   pend;
  logic   refresh_due;
  logic   accept;
  logic   wr0, wr1, wr2;
  logic   set_sync;
  logic   clr_pairs;

`ifdef BMU_CTRL_TIMEOUT_EN
  localparam logic [3:0] TO_LIM = 4'(TIMEOUT - 1);
  logic [3:0] wait_cnt;
  logic       to_hit;
`endif

  // A request arriving this cycle counts as pending so refresh beats a simultaneous symbol.
  assign refresh_due = pend | refresh_req;

  always_comb begin
    sym_ready = 1'b0;
    case (state)
      IDLE:         sym_ready = rst & ~refresh_due;
      LOAD1, LOAD2: sym_ready = rst;
      default:      sym_ready = 1'b0;
    endcase
  end

  assign accept = sym_valid & sym_ready;

  always_comb begin
    nxt       = state;
    wr0       = 1'b0;
    wr1       = 1'b0;
    wr2       = 1'b0;
    set_sync  = 1'b0;
    clr_pairs = 1'b0;
`ifdef BMU_CTRL_TIMEOUT_EN
    to_hit    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (refresh_due) begin
          nxt = REFRESH;
        end else if (accept) begin
          wr0 = 1'b1;
          nxt = LOAD1;
        end
      end
      LOAD1, LOAD2: begin
        if (accept) begin
          if (sym_first) begin
            wr0      = 1'b1;
            set_sync = 1'b1;
            nxt      = LOAD1;
          end else if (state == LOAD1) begin
            wr1 = 1'b1;
            nxt = LOAD2;
          end else begin
            wr2 = 1'b1;
            nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bmu_valid) begin
          nxt = DONE;
        end
`ifdef BMU_CTRL_TIMEOUT_EN
        else if (wait_cnt == TO_LIM) begin
          to_hit = 1'b1;
          nxt    = REFRESH;
        end
`endif
      end
      DONE:    nxt = refresh_due ? REFRESH : IDLE;
      REFRESH: begin
        clr_pairs = 1'b1;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pend       <= 1'b0;
      bit_pair_0 <= '0;
      bit_pair_1 <= '0;
      bit_pair_2 <= '0;
      group_cnt  <= '0;
      err_sync   <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == REFRESH) begin
        pend <= 1'b0;
      end else if (refresh_req) begin
        pend <= 1'b1;
      end
      if (clr_pairs) begin
        bit_pair_0 <= '0;
        bit_pair_1 <= '0;
        bit_pair_2 <= '0;
      end else begin
        if (wr0) bit_pair_0 <= sym_data;
        if (wr1) bit_pair_1 <= sym_data;
        if (wr2) bit_pair_2 <= sym_data;
      end
      if (state == DONE) begin
        group_cnt <= group_cnt + 8'd1;
      end
      if (set_sync) begin
        err_sync <= 1'b1;
      end
    end
  end

`ifdef BMU_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : '0;
      if (to_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  // Timeout logic absent; TIMEOUT is kept so existing instantiations still elaborate.
  assign err_timeout = (TIMEOUT == 0) ? 1'b0 : 1'b0;
`endif

  assign refresh    = (state == REFRESH);
  assign group_done = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_bmu_ctrl.sv
// Self-checking bench for bmu_ctrl: cycle model compared every cycle plus literal scenario checks.
module tb_bmu_ctrl;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       sym_first;
  logic       sym_ready;
  logic       refresh_req;
  logic       bmu_valid;
  logic [1:0] bit_pair_0, bit_pair_1, bit_pair_2;
  logic       refresh, group_done;
  logic [7:0] group_cnt;
  logic       busy, err_sync, err_timeout;

  int n_tot = 0;
  int n_bad = 0;

  bmu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_first(sym_first),
    .sym_ready(sym_ready), .refresh_req(refresh_req), .bmu_valid(bmu_valid),
    .bit_pair_0(bit_pair_0), .bit_pair_1(bit_pair_1), .bit_pair_2(bit_pair_2),
    .refresh(refresh), .group_done(group_done), .group_cnt(group_cnt),
    .busy(busy), .err_sync(err_sync), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Model: a group is tracked by how many pairs have been taken, plus
  // flags for the result wait, the done cycle and the refresh cycle.
  bit        started = 1'b0;
  int        m_nload;
  bit        m_wait, m_done, m_refr, m_pend, m_sync, m_to;
  int        m_wcyc;
  int        m_cnt;
  bit [1:0]  m_p [3];

`ifdef BMU_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  function automatic bit m_busy();
    return (m_nload != 0) || m_wait || m_done || m_refr;
  endfunction

  function automatic bit m_ready();
    if (!rst) return 1'b0;
    if (m_nload != 0) return 1'b1;
    return !m_busy() && !(m_pend || refresh_req);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit acc, rdue;
    if (!rst) begin
      started = 1'b1;
      m_nload = 0; m_wait = 0; m_done = 0; m_refr = 0; m_pend = 0;
      m_sync = 0; m_to = 0; m_wcyc = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) m_p[i] = 2'b00;
    end else if (started) begin
      rdue = m_pend || refresh_req;
      acc  = sym_valid && m_ready();
      if (m_refr) begin
        for (int i = 0; i < 3; i++) m_p[i] = 2'b00;
        m_refr = 0;
      end else if (m_done) begin
        m_cnt  = (m_cnt + 1) % 256;
        m_done = 0;
        m_refr = rdue;
      end else if (m_wait) begin
        if (bmu_valid) begin
          m_wait = 0; m_done = 1;
        end else if (TO_EN && m_wcyc == int'(TO) - 1) begin
          m_wait = 0; m_refr = 1; m_to = 1;
        end else begin
          m_wcyc++;
        end
      end else if (m_nload == 0) begin
        if (rdue) m_refr = 1;
        else if (acc) begin m_p[0] = sym_data; m_nload = 1; end
      end else if (acc) begin
        if (sym_first) begin
          m_p[0] = sym_data; m_nload = 1; m_sync = 1;
        end else begin
          m_p[m_nload] = sym_data;
          m_nload++;
          if (m_nload == 3) begin m_nload = 0; m_wait = 1; m_wcyc = 0; end
        end
      end
      if (m_refr) m_pend = 0;
      else if (refresh_req) m_pend = 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("sym_ready",   32'(sym_ready),   32'(m_ready()));
      chk("bit_pair_0",  32'(bit_pair_0),  32'(m_p[0]));
      chk("bit_pair_1",  32'(bit_pair_1),  32'(m_p[1]));
      chk("bit_pair_2",  32'(bit_pair_2),  32'(m_p[2]));
      chk("refresh",     32'(refresh),     32'(m_refr));
      chk("group_done",  32'(group_done),  32'(m_done));
      chk("group_cnt",   32'(group_cnt),   32'(m_cnt));
      chk("busy",        32'(busy),        32'(m_busy()));
      chk("err_sync",    32'(err_sync),    32'(m_sync));
      chk("err_timeout", 32'(err_timeout), 32'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] d, input logic f);
    sym_valid = 1'b1; sym_data = d; sym_first = f;
    tick();
  endtask

  initial begin
    int start_cnt;
    rst = 1'b0; sym_valid = 1'b0; sym_data = 2'b00; sym_first = 1'b0;
    refresh_req = 1'b0; bmu_valid = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(group_cnt), 0);
    chk("rst_ready_low", 32'(sym_ready), 0);
    rst = 1'b1;
    #1;
    chk("ready_after_release", 32'(sym_ready), 1);

    // Basic group 00,11,01 with result three cycles into WAIT
    put(2'b00, 1'b1);
    put(2'b11, 1'b0);
    put(2'b01, 1'b0);
    sym_valid = 1'b0; sym_first = 1'b0;
    chk("g1_bp0", 32'(bit_pair_0), 32'h0);
    chk("g1_bp1", 32'(bit_pair_1), 32'h3);
    chk("g1_bp2", 32'(bit_pair_2), 32'h1);
    chk("g1_wait_ready", 32'(sym_ready), 0);
    tick(); tick();
    bmu_valid = 1'b1;
    tick();
    bmu_valid = 1'b0;
    chk("g1_done", 32'(group_done), 1);
    tick();
    chk("g1_done_gone", 32'(group_done), 0);
    chk("g1_cnt", 32'(group_cnt), 1);

    // Resync: 10,01 then sym_first with 11 while in LOAD2
    put(2'b10, 1'b1);
    put(2'b01, 1'b0);
    put(2'b11, 1'b1);
    sym_valid = 1'b0; sym_first = 1'b0;
    chk("rs_bp0", 32'(bit_pair_0), 32'h3);
    chk("rs_bp1_kept", 32'(bit_pair_1), 32'h1);
    chk("rs_err_sync", 32'(err_sync), 1);
    chk("rs_cnt", 32'(group_cnt), 1);
    chk("rs_load1_ready", 32'(sym_ready), 1);
    tick(); tick();
    chk("rs_hold_bp0", 32'(bit_pair_0), 32'h3);
    put(2'b00, 1'b0);
    put(2'b10, 1'b0);
    sym_valid = 1'b0;

    // Refresh requested during WAIT is serviced after DONE
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    chk("rw_still_busy", 32'(busy), 1);
    chk("rw_no_refresh", 32'(refresh), 0);
    bmu_valid = 1'b1;
    tick();
    bmu_valid = 1'b0;
    chk("rw_done", 32'(group_done), 1);
    chk("rw_done_no_refresh", 32'(refresh), 0);
    tick();
    chk("rw_refresh", 32'(refresh), 1);
    chk("rw_refresh_no_done", 32'(group_done), 0);
    chk("rw_cnt", 32'(group_cnt), 2);
    tick();
    chk("rw_bp0_clr", 32'(bit_pair_0), 0);
    chk("rw_bp2_clr", 32'(bit_pair_2), 0);
    chk("rw_idle", 32'(busy), 0);

    // Refresh and symbol together in IDLE: refresh first, symbol after
    refresh_req = 1'b1; sym_valid = 1'b1; sym_data = 2'b10; sym_first = 1'b1;
    #1;
    chk("ri_ready_low", 32'(sym_ready), 0);
    tick();
    refresh_req = 1'b0;
    chk("ri_refresh", 32'(refresh), 1);
    chk("ri_refresh_ready", 32'(sym_ready), 0);
    tick();
    chk("ri_idle_ready", 32'(sym_ready), 1);
    tick();
    sym_valid = 1'b0; sym_first = 1'b0;
    chk("ri_bp0", 32'(bit_pair_0), 32'h2);
    put(2'b01, 1'b0);
    put(2'b11, 1'b0);
    sym_valid = 1'b0;

    // WAIT with no result
`ifdef BMU_CTRL_TIMEOUT_EN
    tick(); tick(); tick();
    chk("to_not_yet", 32'(err_timeout), 0);
    chk("to_still_wait", 32'(busy), 1);
    tick();
    chk("to_err", 32'(err_timeout), 1);
    chk("to_refresh", 32'(refresh), 1);
    chk("to_no_done", 32'(group_done), 0);
    tick();
    chk("to_cnt", 32'(group_cnt), 2);
    start_cnt = 2;
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nt_wait_busy", 32'(busy), 1);
    chk("nt_wait_ready", 32'(sym_ready), 0);
    chk("nt_err_timeout", 32'(err_timeout), 0);
    bmu_valid = 1'b1;
    tick();
    bmu_valid = 1'b0;
    tick();
    chk("nt_cnt", 32'(group_cnt), 3);
    start_cnt = 3;
`endif

    // Wrap group_cnt through 255 -> 0
    for (int g = start_cnt; g < 256; g++) begin
      put(2'(g), 1'b1);
      put(2'(g + 1), 1'b0);
      put(2'(g + 2), 1'b0);
      sym_valid = 1'b0; sym_first = 1'b0;
      bmu_valid = 1'b1;
      tick();
      bmu_valid = 1'b0;
      tick();
    end
    chk("wrap_cnt", 32'(group_cnt), 0);

    // Reset mid-LOAD2 discards the partial group
    put(2'b11, 1'b1);
    put(2'b01, 1'b1);
    put(2'b10, 1'b0);
    sym_valid = 1'b1; sym_data = 2'b01; sym_first = 1'b0;
    chk("pre_rst_sync", 32'(err_sync), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(sym_ready), 0);
    tick();
    sym_valid = 1'b0;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_bp0", 32'(bit_pair_0), 0);
    chk("mr_bp1", 32'(bit_pair_1), 0);
    chk("mr_done", 32'(group_done), 0);
    chk("mr_cnt", 32'(group_cnt), 0);
    chk("mr_sync", 32'(err_sync), 0);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/bmu_ctrl.md
BMU_CTRL -- requirements
Module: bmu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: WAIT-state cycle limit (4-bit counter, 1..15).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 sym_valid  in  1  upstream symbol valid.
REQ-005 sym_data  in  2  received bit pair.
REQ-006 sym_first  in  1  qualifies sym_data as the first pair of a 3-pair group.
REQ-007 sym_ready  out  1  block accepts sym_data this cycle.
REQ-008 refresh_req  in  1  host request to clear the BMU pipeline.
REQ-009 bmu_valid  in  1  valid_out of the final BMU stage.
REQ-010 bit_pair_0, bit_pair_1, bit_pair_2  out  2 each  registered pairs driven to BMU stages 1/2/3.
REQ-011 refresh  out  1  one-cycle refresh pulse to all BMU stages.
REQ-012 group_done  out  1  one-cycle pulse: BMU result for current group valid.
REQ-013 group_cnt  out  8  completed groups, wraps 255->0.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 err_sync  out  1  sticky: group resynchronised by sym_first.
REQ-016 err_timeout  out  1  sticky: bmu_valid not seen within TIMEOUT cycles.

Function
REQ-017 FSM states SHALL be IDLE, LOAD1, LOAD2, WAIT, DONE, REFRESH.
REQ-018 Accept occurs when sym_valid && sym_ready; sym_ready = 1 in IDLE (no refresh pending), LOAD1, LOAD2; 0 in WAIT, DONE, REFRESH.
REQ-019 IDLE: accept -> bit_pair_0 <= sym_data, go LOAD1.
REQ-020 LOAD1: accept -> bit_pair_1 <= sym_data, go LOAD2; LOAD2: accept -> bit_pair_2 <= sym_data, go WAIT, clear wait counter.
REQ-021 Accept with sym_first = 1 in LOAD1 or LOAD2 SHALL write bit_pair_0, go LOAD1, set err_sync; sym_first in IDLE is normal.
REQ-022 No accept in LOAD1/LOAD2: hold state and pairs indefinitely.
REQ-023 WAIT: bmu_valid = 1 -> DONE; bmu_valid outside WAIT SHALL be ignored.
REQ-024 DONE (one cycle): group_done = 1, group_cnt += 1 mod 256; go REFRESH if refresh pending, else IDLE.
REQ-025 refresh_req sampled high in any state sets pending flag; flag cleared on REFRESH entry.
REQ-026 IDLE with pending flag: sym_ready = 0, go REFRESH (refresh wins over a simultaneous sym_valid).
REQ-027 REFRESH (one cycle): refresh = 1, bit_pair_0..2 <= 00, go IDLE.
REQ-028 Pending refresh in LOAD1/LOAD2/WAIT SHALL NOT abort the group; serviced after DONE.
REQ-029 bit_pair_0..2 change only on accept or in REFRESH; latency accept-of-third-pair -> WAIT = 1 cycle.
REQ-030 group_done and refresh never assert in the same cycle.

Reset
REQ-031 rst = 0 at a rising edge: state IDLE, bit_pair_0..2 = 00, refresh = 0, group_done = 0, group_cnt = 0, busy = 0, err_sync = 0, err_timeout = 0, pending flag and wait counter = 0.
REQ-032 Reset mid-group SHALL discard partial group, no group_done; sym_ready = 0 while rst = 0, 1 in first cycle after release.
REQ-033 Sticky errors clear only by reset.

Configuration
REQ-034 Macro BMU_CTRL_TIMEOUT_EN defined: wait counter increments each WAIT cycle; reaching TIMEOUT without bmu_valid sets err_timeout, goes REFRESH (no group_done, group_cnt unchanged).
REQ-035 Macro undefined: no counter; WAIT holds until bmu_valid; err_timeout tied 0.

Verification
REQ-036 Reset, pairs 00,11,01 (sym_first on first), bmu_valid 3 cycles after WAIT -> bit_pairs 00/11/01, group_done one cycle, group_cnt = 1.
REQ-037 Pairs 10,01 then sym_first with 11 in LOAD2 -> bit_pair_0 = 11, state LOAD1, err_sync = 1, group_cnt unchanged.
REQ-038 refresh_req pulsed during WAIT -> group completes, DONE then refresh = 1 next cycle, bit_pairs = 00, IDLE.
REQ-039 refresh_req and sym_valid together in IDLE -> sym_ready = 0, refresh pulse, symbol accepted cycle after.
REQ-040 With BMU_CTRL_TIMEOUT_EN, TIMEOUT = 4, bmu_valid held 0 -> err_timeout = 1 after 4 WAIT cycles, refresh pulse, group_cnt unchanged; without macro, block stays in WAIT.
REQ-041 256 groups completed -> group_cnt wraps to 0; rst = 0 mid-LOAD2 -> all outputs at reset values next edge.
